// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a byte-wide
// memory. A granted 64-bit access is split into BEATS byte transfers; an
// out-of-range address completes immediately with an error pulse and no
// memory strobes. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned BEATS     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_req,
  input  logic        i_a_we,
  input  logic [63:0] i_a_addr,
  input  logic [63:0] i_a_wdata,
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [63:0] i_b_addr,
  input  logic [63:0] i_b_wdata,
  output logic        o_a_ack,
  output logic        o_b_ack,
  output logic        o_a_err,
  output logic        o_b_err,
  output logic [63:0] o_rdata,
  output logic [63:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_mem_re,
  input  logic [7:0]  i_mem_rdata
);

  localparam int unsigned      CW          = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]    LP_LAST     = CW'(BEATS - 1);
  localparam logic [CW-1:0]    LP_ONE      = CW'(1);
  localparam logic [63:0]      LP_MAX_ADDR = 64'(MEM_BYTES - BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_last_b;   // 1: B was served last, so A wins a tie
  logic          r_sel_b;    // requester owning the current access
  logic          r_we;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          r_a_ack;
  logic          r_b_ack;
  logic          r_a_err;
  logic          r_b_err;
  logic [63:0]   r_rdata;
  logic [63:0]   r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_mem_we;
  logic          r_mem_re;

  logic          w_any;
  logic          w_grant_b;
  logic [CW-1:0] w_cnt_nxt;

  // Byte idx of a little-endian 64-bit word.
  function automatic logic [7:0] f_byte(input logic [63:0] data, input logic [CW-1:0] idx);
    f_byte = data[{idx, 3'b000} +: 8];
  endfunction

  assign w_any     = i_a_req | i_b_req;
  assign w_cnt_nxt = r_cnt + LP_ONE;

  // Round-robin winner: a lone request always wins, a tie goes to the side not served last.
  always_comb begin
    w_grant_b = 1'b0;
    if (i_a_req && i_b_req) begin
      w_grant_b = ~r_last_b;
    end else if (i_b_req) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_b = 1'b0;
    end
  end

  // Arbitration FSM with registered handshake and memory-port outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_last_b    <= 1'b1;
      r_sel_b     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 64'h0;
      r_wdata     <= 64'h0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_err     <= 1'b0;
      r_b_err     <= 1'b0;
      r_rdata     <= 64'h0;
      r_mem_addr  <= 64'h0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel_b    <= w_grant_b;
            r_last_b   <= w_grant_b;
            r_we       <= w_grant_b ? i_b_we    : i_a_we;
            r_addr     <= w_grant_b ? i_b_addr  : i_a_addr;
            r_wdata    <= w_grant_b ? i_b_wdata : i_a_wdata;
            r_mem_addr <= w_grant_b ? i_b_addr  : i_a_addr;
            r_err      <= 1'b0;
            r_state    <= ST_GRANT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (r_addr > LP_MAX_ADDR) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt       <= '0;
            r_mem_addr  <= r_addr;
            r_mem_we    <= r_we;
            r_mem_re    <= ~r_we;
            r_mem_wdata <= r_we ? f_byte(r_wdata, '0) : 8'h00;
            r_state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!r_we) begin
            r_rdata[{r_cnt, 3'b000} +: 8] <= i_mem_rdata;
          end else begin
            r_rdata <= r_rdata;
          end
          if (r_cnt == LP_LAST) begin
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_wdata <= 8'h00;
            r_mem_addr  <= r_addr;
            r_state     <= ST_DONE;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= r_addr + 64'(w_cnt_nxt);
            r_mem_wdata <= r_we ? f_byte(r_wdata, w_cnt_nxt) : 8'h00;
            r_state     <= ST_XFER;
          end
        end
        ST_DONE: begin
          r_a_ack <= ~r_sel_b;
          r_b_ack <= r_sel_b;
          r_a_err <= r_err & ~r_sel_b;
          r_b_err <= r_err & r_sel_b;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_a_ack     = r_a_ack;
  assign o_b_ack     = r_b_ack;
  assign o_a_err     = r_a_err;
  assign o_b_err     = r_b_err;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A reference model grants
// requests by the round-robin rule, applies accesses to its own byte array
// and queues the expected completion; a monitor checks every ack against it.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack, a_err, b_err;
  logic [63:0] rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [7:0]  bmem    [64];   // memory driven by the DUT
  logic [7:0]  ref_mem [64];   // model's view of memory

  typedef struct {
    bit          who_b;
    bit          err;
    logic [63:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t        sb_q[$];
  bit          act_order[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          exp_strobes = 0;
  bit          last_b = 1'b1;
  int          next_free = 0;
  logic [63:0] exp_rdata = 64'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(64), .BEATS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_a_ack(a_ack), .o_b_ack(b_ack), .o_a_err(a_err), .o_b_err(b_err),
    .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 64'd64) ? bmem[mem_addr[5:0]] : 8'h00;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d (t=%0t)", name, cyc, $time);
  endtask

  // Memory array written by the DUT's strobes.
  initial begin
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 64'd64) bmem[mem_addr[5:0]] = mem_wdata;
    end
  end

  // Reference model: serialised accesses, round-robin on ties.
  initial begin
    bit          m_b;
    logic        m_we;
    logic [63:0] m_ad, m_wd;
    exp_t        m_e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        last_b    = 1'b1;
        next_free = 0;
        exp_rdata = 64'h0;
      end else if (cyc >= next_free && (a_req || b_req)) begin
        m_b    = (a_req && b_req) ? !last_b : b_req;
        last_b = m_b;
        m_we   = m_b ? b_we : a_we;
        m_ad   = m_b ? b_addr : a_addr;
        m_wd   = m_b ? b_wdata : a_wdata;
        m_e.who_b = m_b;
        m_e.err   = (m_ad > 64'd56);
        if (!m_e.err) begin
          exp_strobes += 8;
          for (int k = 0; k < 8; k++) begin
            if (m_we) ref_mem[int'(m_ad[5:0]) + k] = m_wd[8*k +: 8];
            else exp_rdata[8*k +: 8] = ref_mem[int'(m_ad[5:0]) + k];
          end
        end
        m_e.rdata   = exp_rdata;
        m_e.ack_cyc = cyc + (m_e.err ? 2 : 10);
        next_free   = m_e.ack_cyc + 1;
        sb_q.push_back(m_e);
      end
    end
  end

  // Monitor: compares each completion with the scoreboard head.
  initial begin
    exp_t m_e;
    forever begin
      @(negedge clk);
      if (mem_we || mem_re) strobes++;
      if (rst_n) begin
        if (a_ack && b_ack) fail_evt("dual_ack");
        if ((a_err && !a_ack) || (b_err && !b_ack)) fail_evt("err_without_ack");
        if (a_ack || b_ack) begin
          if (sb_q.size() == 0) begin
            fail_evt("ack_without_request");
          end else begin
            m_e = sb_q.pop_front();
            act_order.push_back(b_ack);
            check64("ack_requester", {63'd0, b_ack}, {63'd0, m_e.who_b});
            check64("ack_err", {63'd0, (b_ack ? b_err : a_err)}, {63'd0, m_e.err});
            check64("ack_rdata", rdata, m_e.rdata);
            check64("ack_cycle", 64'(cyc), 64'(m_e.ack_cyc));
          end
        end else if (sb_q.size() > 0 && cyc > sb_q[0].ack_cyc) begin
          fail_evt("ack_timeout");
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic set_a(input logic req, input logic we, input logic [63:0] ad, input logic [63:0] wd);
    a_req = req; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [63:0] ad, input logic [63:0] wd);
    b_req = req; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) @(negedge clk);
    check64("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  old_b [8];
    bit          hit;
    int          r;

    rst_n = 1'b0;
    set_a(1'b0, 1'b0, 64'h0, 64'h0);
    set_b(1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 64; i++) begin
      bmem[i]    = 8'($urandom);
      ref_mem[i] = bmem[i];
    end
    repeat (3) @(negedge clk);
    check64("rst_acks", {60'd0, a_ack, b_ack, a_err, b_err}, 64'd0);
    check64("rst_strobes", {62'd0, mem_we, mem_re}, 64'd0);
    check64("rst_rdata", rdata, 64'h0);
    check64("rst_mem_addr", mem_addr, 64'h0);
    check64("rst_mem_wdata", {56'd0, mem_wdata}, 64'h0);
    rst_n = 1'b1;

    // Simultaneous requests held high: four grants alternating A, B, A, B.
    @(negedge clk);
    set_a(1'b1, 1'b0, 64'd0, 64'h0);
    set_b(1'b1, 1'b0, 64'd16, 64'h0);
    repeat (40) @(negedge clk);
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    set_b(1'b0, 1'b0, 64'd16, 64'h0);
    drain(30);
    check64("pair_count", 64'(act_order.size()), 64'd4);
    if (act_order.size() >= 4) begin
      check64("pair_order", {60'd0, act_order[0], act_order[1], act_order[2], act_order[3]}, 64'b0101);
    end

    // Store then load of a known word at address 8.
    set_a(1'b1, 1'b1, 64'd8, 64'h1122334455667788);
    @(negedge clk);
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    drain(20);
    set_a(1'b1, 1'b0, 64'd8, 64'h0);
    @(negedge clk);
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    drain(20);
    check64("load_word8", rdata, 64'h1122334455667788);
    check64("mem_byte8", {56'd0, bmem[8]}, 64'h88);
    check64("mem_byte15", {56'd0, bmem[15]}, 64'h11);

    // Out-of-range B load, then the highest legal address.
    set_b(1'b1, 1'b0, 64'd57, 64'h0);
    @(negedge clk);
    set_b(1'b0, 1'b0, 64'd0, 64'h0);
    drain(10);
    check64("err_keeps_rdata", rdata, 64'h1122334455667788);
    set_b(1'b1, 1'b0, 64'd56, 64'h0);
    @(negedge clk);
    set_b(1'b0, 1'b0, 64'd0, 64'h0);
    drain(20);

    // Request dropped and address changed while the transfer runs.
    set_a(1'b1, 1'b0, 64'd16, 64'h0);
    @(negedge clk);
    set_a(1'b0, 1'b1, 64'd40, 64'hdeadbeefcafef00d);
    drain(20);

    // Request held across ack: back-to-back stores.
    set_a(1'b1, 1'b1, 64'd24, {$urandom, $urandom});
    repeat (25) @(negedge clk);
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    drain(30);

    // Random traffic; fields may change freely while requests are pending.
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 2; s++) begin
        r = $urandom_range(15, 0);
        if (r == 0) d = {$urandom, $urandom};
        else if (r == 1) d = 64'($urandom_range(63, 57));
        else d = 64'($urandom_range(56, 0));
        if (s == 0) set_a(($urandom_range(2, 0) != 0), 1'($urandom), d, {$urandom, $urandom});
        else set_b(($urandom_range(2, 0) != 0), 1'($urandom), d, {$urandom, $urandom});
      end
      @(negedge clk);
    end
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    set_b(1'b0, 1'b0, 64'd0, 64'h0);
    drain(60);
    check64("strobe_cycles", 64'(strobes), 64'(exp_strobes));
    for (int i = 0; i < 64; i++) check64("mem_contents", {56'd0, bmem[i]}, {56'd0, ref_mem[i]});

    // Reset during beat 3 of a store at address 0.
    for (int i = 0; i < 8; i++) old_b[i] = bmem[i];
    d = {$urandom, $urandom};
    set_a(1'b1, 1'b1, 64'd0, d);
    @(negedge clk);
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 64'd3) hit = 1'b1;
    end
    check64("beat3_reached", {63'd0, hit}, 64'd1);
    rst_n = 1'b0;
    #1;
    check64("rst_async_strobes", {62'd0, mem_we, mem_re}, 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    check64("rst_no_ack", {62'd0, a_ack, b_ack}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      check64("aborted_store_bytes", {56'd0, bmem[i]}, {56'd0, (i < 3) ? d[8*i +: 8] : old_b[i]});
      ref_mem[i] = (i < 3) ? d[8*i +: 8] : old_b[i];
    end
    rst_n = 1'b1;
    set_a(1'b1, 1'b0, 64'd0, 64'h0);
    @(negedge clk);
    set_a(1'b0, 1'b0, 64'd0, 64'h0);
    drain(20);
    check64("post_reset_load", rdata, {old_b[7], old_b[6], old_b[5], old_b[4], old_b[3], d[23:0]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
